// File: rtl/noc_link_pkg.sv
// Shared types and constants for the credit-based NoC link stage.
//   link_state_e     : wormhole framing checker states
//   ERR_*            : bit positions of the sticky error flags
//   credit_cnt_width : width needed to hold 0..depth inclusive
package noc_link_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } link_state_e;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UNF = 1;
  localparam int unsigned ERR_FRM = 2;
  localparam int unsigned NUM_ERR = 3;

  function automatic int unsigned credit_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_link_delay_line.sv
// Fixed-latency retiming line for long inter-tile wires.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   valid_i/o     : qualifier bit, reset to 0 in every stage
//   data_i/o      : payload bits, not reset (only meaningful with valid)
// STAGES = 0 degenerates to plain wires.
module noc_link_delay_line #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  if (STAGES == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign valid_o        = valid_i;
    assign data_o         = data_i;
  end else begin : g_pipe
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] data_q  [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < STAGES; i++) valid_q[i] <= 1'b0;
      end else begin
        valid_q[0] <= valid_i;
        for (int i = 1; i < STAGES; i++) valid_q[i] <= valid_q[i-1];
      end
    end

    // Payload needs no reset: consumers qualify it with the valid bit.
    always_ff @(posedge clk_i) begin
      data_q[0] <= data_i;
      for (int i = 1; i < STAGES; i++) data_q[i] <= data_q[i-1];
    end

    assign valid_o = valid_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];
  end

endmodule

// File: rtl/noc_credit_link.sv
// Credit-based router-to-router link stage with protocol checking.
//   clk_noc, rst_n            : NoC clock, asynchronous active-low reset
//   data_in/dest_in/is_tail_in/send_in -> data_out/dest_out/is_tail_out/send_out
//                               : forward flit path, NUM_PIPELINE cycles
//   credit_in -> credit_out   : reverse credit path, NUM_PIPELINE cycles
//   clear_stats               : synchronous clear of counters and error flags
//   flit_count/packet_count   : wrapping debug counters of upstream traffic
//   err_credit_overflow/underflow, err_framing : sticky protocol error flags
module noc_credit_link
  import noc_link_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH        = 64,
  parameter int unsigned DEST_WIDTH        = 4,
  parameter int unsigned FLIT_BUFFER_DEPTH = 8,
  parameter int unsigned NUM_PIPELINE      = 0,
  parameter int unsigned COUNT_WIDTH       = 16
) (
  input  logic                   clk_noc,
  input  logic                   rst_n,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic [FLIT_WIDTH-1:0]  data_out,
  output logic [DEST_WIDTH-1:0]  dest_out,
  output logic                   is_tail_out,
  output logic                   send_out,
  input  logic                   credit_in,
  input  logic                   clear_stats,
  output logic [COUNT_WIDTH-1:0] flit_count,
  output logic [COUNT_WIDTH-1:0] packet_count,
  output logic                   err_credit_overflow,
  output logic                   err_credit_underflow,
  output logic                   err_framing
);

  localparam int unsigned FwdW = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam int unsigned CntW = credit_cnt_width(FLIT_BUFFER_DEPTH);
  localparam logic [CntW-1:0] CntMax = CntW'(FLIT_BUFFER_DEPTH);

  // Delay lines
  logic credit_payload_unused;

  noc_link_delay_line #(
    .WIDTH  (FwdW),
    .STAGES (NUM_PIPELINE)
  ) u_fwd (
    .clk_i   (clk_noc),
    .rst_ni  (rst_n),
    .valid_i (send_in),
    .data_i  ({data_in, dest_in, is_tail_in}),
    .valid_o (send_out),
    .data_o  ({data_out, dest_out, is_tail_out})
  );

  noc_link_delay_line #(
    .WIDTH  (1),
    .STAGES (NUM_PIPELINE)
  ) u_crd (
    .clk_i   (clk_noc),
    .rst_ni  (rst_n),
    .valid_i (credit_in),
    .data_i  (1'b0),
    .valid_o (credit_out),
    .data_o  (credit_payload_unused)
  );

  // Shadow credit counter, observed on the upstream side of the link.
  logic [CntW-1:0] credit_cnt_q, credit_cnt_d;
  logic            ovf_evt, unf_evt;

  always_comb begin
    credit_cnt_d = credit_cnt_q;
    ovf_evt      = 1'b0;
    unf_evt      = 1'b0;
    if (send_in && !credit_out) begin
      if (credit_cnt_q == '0) ovf_evt = 1'b1;
      else                    credit_cnt_d = credit_cnt_q - 1'b1;
    end else if (credit_out && !send_in) begin
      if (credit_cnt_q == CntMax) unf_evt = 1'b1;
      else                        credit_cnt_d = credit_cnt_q + 1'b1;
    end
  end

  // Wormhole framing checker: every flit of a packet must carry the head's dest.
  link_state_e           state_q, state_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  frm_evt;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    frm_evt = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (send_in && !is_tail_in) begin
          dest_d  = dest_in;
          state_d = IN_PKT;
        end
      end
      IN_PKT: begin
        if (send_in) begin
          if (dest_in != dest_q) frm_evt = 1'b1;
          if (is_tail_in)        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Statistics and sticky flags; a same-cycle clear discards the event.
  logic [COUNT_WIDTH-1:0] flit_cnt_q, flit_cnt_d;
  logic [COUNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [NUM_ERR-1:0]     err_q, err_d, err_evt;

  always_comb begin
    err_evt          = '0;
    err_evt[ERR_OVF] = ovf_evt;
    err_evt[ERR_UNF] = unf_evt;
    err_evt[ERR_FRM] = frm_evt;
    if (clear_stats) begin
      flit_cnt_d = '0;
      pkt_cnt_d  = '0;
      err_d      = '0;
    end else begin
      flit_cnt_d = flit_cnt_q + COUNT_WIDTH'(send_in);
      pkt_cnt_d  = pkt_cnt_q + COUNT_WIDTH'(send_in && is_tail_in);
      err_d      = err_q | err_evt;
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt_q <= CntMax;
      state_q      <= IDLE;
      dest_q       <= '0;
      flit_cnt_q   <= '0;
      pkt_cnt_q    <= '0;
      err_q        <= '0;
    end else begin
      credit_cnt_q <= credit_cnt_d;
      state_q      <= state_d;
      dest_q       <= dest_d;
      flit_cnt_q   <= flit_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_q        <= err_d;
    end
  end

  assign flit_count           = flit_cnt_q;
  assign packet_count         = pkt_cnt_q;
  assign err_credit_overflow  = err_q[ERR_OVF];
  assign err_credit_underflow = err_q[ERR_UNF];
  assign err_framing          = err_q[ERR_FRM];

endmodule

// File: tb/tb_noc_credit_link.sv
module tb_noc_credit_link;
  import noc_link_pkg::*;

  localparam int P     = 2;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic        clk_noc = 1'b0;
  logic        rst_n;
  logic [63:0] data_in;
  logic [3:0]  dest_in;
  logic        is_tail_in, send_in, credit_in, clear_stats;

  logic        credit_out, is_tail_out, send_out;
  logic [63:0] data_out;
  logic [3:0]  dest_out;
  logic [CW-1:0] flit_count, packet_count;
  logic        err_ovf, err_unf, err_frm;

  logic        credit_out_c, is_tail_out_c, send_out_c;
  logic [63:0] data_out_c;
  logic [3:0]  dest_out_c;
  logic [15:0] flit_count_c, packet_count_c;
  logic [2:0]  unused_flags_c;

  always #5 clk_noc = ~clk_noc;

  noc_credit_link #(
    .FLIT_WIDTH(64), .DEST_WIDTH(4), .FLIT_BUFFER_DEPTH(DEPTH),
    .NUM_PIPELINE(P), .COUNT_WIDTH(CW)
  ) dut (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .clear_stats(clear_stats),
    .flit_count(flit_count), .packet_count(packet_count),
    .err_credit_overflow(err_ovf), .err_credit_underflow(err_unf), .err_framing(err_frm)
  );

  // Pass-through flavour sharing the same stimulus.
  noc_credit_link #(
    .FLIT_WIDTH(64), .DEST_WIDTH(4), .FLIT_BUFFER_DEPTH(DEPTH),
    .NUM_PIPELINE(0), .COUNT_WIDTH(16)
  ) u_comb (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out_c),
    .data_out(data_out_c), .dest_out(dest_out_c), .is_tail_out(is_tail_out_c),
    .send_out(send_out_c), .credit_in(credit_in), .clear_stats(clear_stats),
    .flit_count(flit_count_c), .packet_count(packet_count_c),
    .err_credit_overflow(unused_flags_c[0]), .err_credit_underflow(unused_flags_c[1]),
    .err_framing(unused_flags_c[2])
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  typedef struct packed {
    logic        send;
    logic [63:0] data;
    logic [3:0]  dest;
    logic        tail;
  } flit_t;

  flit_t fwd_q[$];
  logic  crd_q[$];
  int    cnt, fc, pc, fc16, pc16;
  logic  m_ovf, m_unf, m_frm, in_pkt;
  logic [3:0] cap_dest;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fwd_q = {};
    crd_q = {};
    for (int i = 0; i < P; i++) begin
      fwd_q.push_back('0);
      crd_q.push_back(1'b0);
    end
    cnt = DEPTH; fc = 0; pc = 0; fc16 = 0; pc16 = 0;
    m_ovf = 0; m_unf = 0; m_frm = 0; in_pkt = 0; cap_dest = '0;
  endtask

  // Check all outputs against the model, advance the model by one cycle, then clock.
  task automatic tick();
    flit_t head;
    logic  cr, e_ovf, e_unf, e_frm;
    head = fwd_q[0];
    cr   = crd_q[0];
    check("send_out", send_out, head.send);
    if (head.send) begin
      check("data_out", data_out, head.data);
      check("dest_out", dest_out, head.dest);
      check("tail_out", is_tail_out, head.tail);
    end
    check("credit_out", credit_out, cr);
    check("flit_count", flit_count, fc);
    check("packet_count", packet_count, pc);
    check("err_ovf", err_ovf, m_ovf);
    check("err_unf", err_unf, m_unf);
    check("err_frm", err_frm, m_frm);
    check("credit_cnt", dut.credit_cnt_q, cnt);
    check("state", dut.state_q, in_pkt ? IN_PKT : IDLE);
    check("comb_send", send_out_c, send_in);
    check("comb_credit", credit_out_c, credit_in);
    if (send_in) check("comb_data", {data_out_c, dest_out_c, is_tail_out_c},
                       {data_in, dest_in, is_tail_in});
    check("comb_flit_count", flit_count_c, fc16);
    check("comb_packet_count", packet_count_c, pc16);

    e_ovf = 0; e_unf = 0; e_frm = 0;
    if (send_in && !cr) begin
      if (cnt == 0) e_ovf = 1; else cnt--;
    end else if (cr && !send_in) begin
      if (cnt == DEPTH) e_unf = 1; else cnt++;
    end
    if (send_in) begin
      if (in_pkt) begin
        if (dest_in != cap_dest) e_frm = 1;
        if (is_tail_in) in_pkt = 0;
      end else if (!is_tail_in) begin
        in_pkt = 1;
        cap_dest = dest_in;
      end
    end
    if (clear_stats) begin
      fc = 0; pc = 0; fc16 = 0; pc16 = 0; m_ovf = 0; m_unf = 0; m_frm = 0;
    end else begin
      fc   = (fc + int'(send_in)) % (1 << CW);
      pc   = (pc + int'(send_in && is_tail_in)) % (1 << CW);
      fc16 = (fc16 + int'(send_in)) % 65536;
      pc16 = (pc16 + int'(send_in && is_tail_in)) % 65536;
      m_ovf |= e_ovf; m_unf |= e_unf; m_frm |= e_frm;
    end
    void'(fwd_q.pop_front());
    fwd_q.push_back({send_in, data_in, dest_in, is_tail_in});
    void'(crd_q.pop_front());
    crd_q.push_back(credit_in);
    @(posedge clk_noc);
    #1;
  endtask

  task automatic idle_inputs();
    send_in = 0; is_tail_in = 0; credit_in = 0; clear_stats = 0;
  endtask

  task automatic send_flit(input logic [3:0] d, input logic t);
    send_in = 1; dest_in = d; is_tail_in = t; data_in = {$urandom, $urandom};
    tick();
    send_in = 0;
  endtask

  // Return every credit still owed, then let the credit pipe drain.
  task automatic refill();
    int n;
    n = DEPTH - cnt;
    foreach (crd_q[i]) n -= int'(crd_q[i]);
    idle_inputs();
    credit_in = 1;
    repeat (n) tick();
    credit_in = 0;
    repeat (P + 1) tick();
  endtask

  initial begin
    logic [3:0] pkt_dest;
    rst_n = 0;
    data_in = 64'h1234; dest_in = 4'h7;
    idle_inputs();
    send_in = 1; credit_in = 1;
    model_reset();
    #3;
    check("rst_send_out", send_out, 1'b0);
    check("rst_credit_out", credit_out, 1'b0);
    check("rst_flit_count", flit_count, 0);
    check("rst_errs", {err_ovf, err_unf, err_frm}, 3'b000);
    check("rst_comb_send", send_out_c, 1'b1);
    check("rst_comb_credit", credit_out_c, 1'b1);
    check("rst_comb_data", data_out_c, 64'h1234);
    idle_inputs();
    #19 rst_n = 1;
    tick();

    // Latency
    send_in = 1; data_in = 64'hA5; dest_in = 4'h3; is_tail_in = 1;
    tick();
    idle_inputs();
    check("lat_t1_send", send_out, 1'b0);
    tick();
    check("lat_t2_send", send_out, 1'b1);
    check("lat_t2_data", data_out, 64'hA5);
    check("lat_t2_dest", dest_out, 4'h3);
    tick();
    check("lat_t3_send", send_out, 1'b0);
    credit_in = 1;
    tick();
    credit_in = 0;
    check("crd_t1", credit_out, 1'b0);
    tick();
    check("crd_t2", credit_out, 1'b1);
    tick();
    check("crd_back_full", dut.credit_cnt_q, DEPTH);

    // Full throughput then overflow
    for (int i = 0; i < DEPTH; i++) send_flit(4'(i), 1'b1);
    check("thr_cnt_zero", dut.credit_cnt_q, 0);
    check("thr_no_ovf", err_ovf, 1'b0);
    send_flit(4'h0, 1'b1);
    check("ovf_set", err_ovf, 1'b1);
    check("ovf_cnt_hold", dut.credit_cnt_q, 0);

    // Underflow
    refill();
    check("refill_full", dut.credit_cnt_q, DEPTH);
    credit_in = 1;
    tick();
    credit_in = 0;
    repeat (P) tick();
    check("unf_set", err_unf, 1'b1);
    clear_stats = 1;
    tick();
    clear_stats = 0;
    check("clear_flags", {err_ovf, err_unf, err_frm}, 3'b000);

    // Simultaneous send and credit
    repeat (3) send_flit(4'h1, 1'b1);
    credit_in = 1;
    tick();
    credit_in = 0;
    tick();
    send_in = 1; is_tail_in = 1;
    tick();
    send_in = 0;
    check("simul_hold", dut.credit_cnt_q, 5);
    refill();

    // Framing
    clear_stats = 1;
    tick();
    clear_stats = 0;
    send_flit(4'h2, 1'b0);
    send_flit(4'h2, 1'b0);
    send_flit(4'h2, 1'b1);
    check("frm_ok", err_frm, 1'b0);
    check("frm_pkts", packet_count, 1);
    check("frm_flits", flit_count, 3);
    send_flit(4'h2, 1'b0);
    send_flit(4'h1, 1'b1);
    check("frm_err", err_frm, 1'b1);
    refill();
    send_flit(4'h5, 1'b1);
    check("single_idle", dut.state_q, IDLE);
    refill();

    // Wrap and clear
    clear_stats = 1;
    tick();
    clear_stats = 0;
    credit_in = 1;
    repeat (17) send_flit(4'h4, 1'b1);
    credit_in = 0;
    check("wrap_flits", flit_count, 1);
    check("wrap_pkts", packet_count, 1);
    refill();
    send_in = 1; is_tail_in = 1; dest_in = 4'h6; clear_stats = 1;
    tick();
    idle_inputs();
    check("clr_flits", flit_count, 0);
    check("clr_pkts", packet_count, 0);
    check("clr_flags", {err_ovf, err_unf, err_frm}, 3'b000);
    refill();

    // Randomized traffic
    pkt_dest = 4'($urandom_range(0, 3));
    for (int i = 0; i < 400; i++) begin
      int owed;
      owed = DEPTH - cnt;
      foreach (crd_q[j]) owed -= int'(crd_q[j]);
      send_in     = ((cnt > 0) || ($urandom_range(0, 15) == 0)) && ($urandom_range(0, 1) == 1);
      is_tail_in  = ($urandom_range(0, 2) == 0);
      dest_in     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 3)) : pkt_dest;
      data_in     = {$urandom, $urandom};
      credit_in   = ((owed > 0) && ($urandom_range(0, 2) != 0)) || ($urandom_range(0, 31) == 0);
      clear_stats = ($urandom_range(0, 31) == 0);
      if (send_in && is_tail_in) pkt_dest = 4'($urandom_range(0, 3));
      tick();
    end
    idle_inputs();

    // Reset with flits in flight
    refill();
    send_flit(4'h8, 1'b1);
    send_flit(4'h9, 1'b1);
    #2 rst_n = 0;
    #1;
    model_reset();
    check("rst_mid_send_out", send_out, 1'b0);
    @(posedge clk_noc);
    #1;
    check("rst_mid_hold", send_out, 1'b0);
    rst_n = 1;
    repeat (4) tick();
    check("rst_mid_cnt", dut.credit_cnt_q, DEPTH);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_credit_link.md
# noc_credit_link

Credit-based router-to-router link stage placed on each inter-router port of the router wrapper, between one router's output port and the neighbouring router's input port. Forward path carries flit, destination, tail and send signals. Reverse path carries credits. Both paths are retimed through `NUM_PIPELINE` register stages for long inter-tile wires. The link also checks the protocol it carries: a shadow credit counter and a wormhole framing checker raise sticky error flags, and wrapping flit and packet counters are kept for debug.

## Interface
- `FLIT_WIDTH`, 64, flit payload width.
- `DEST_WIDTH`, 4, destination field width (TDEST + TID).
- `FLIT_BUFFER_DEPTH`, 8, downstream input buffer depth; initial credit count.
- `NUM_PIPELINE`, 0, register stages per direction; 0 means a combinational pass-through.
- `COUNT_WIDTH`, 16, width of the statistics counters.

Ports:
- `clk_noc`  in  1  NoC clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  FLIT_WIDTH  flit from upstream router output.
- `dest_in`  in  DEST_WIDTH  destination accompanying every flit.
- `is_tail_in`  in  1  last flit of packet.
- `send_in`  in  1  flit valid.
- `credit_out`  out  1  credit returned to upstream router.
- `data_out`  out  FLIT_WIDTH  flit to downstream router input.
- `dest_out`  out  DEST_WIDTH  destination to downstream router.
- `is_tail_out`  out  1  tail to downstream router.
- `send_out`  out  1  flit valid to downstream router.
- `credit_in`  in  1  credit from downstream router.
- `clear_stats`  in  1  synchronous clear of counters and error flags.
- `flit_count`  out  COUNT_WIDTH  flits accepted at `send_in`.
- `packet_count`  out  COUNT_WIDTH  tails accepted at `send_in`.
- `err_credit_overflow`  out  1  sticky: a flit was sent while the shadow credit count was 0.
- `err_credit_underflow`  out  1  sticky: a credit was returned while the shadow count was full.
- `err_framing`  out  1  sticky: `dest_in` changed inside a packet.

## Operation
**Forward delay line**
- `send`, `is_tail`, `dest` and `data` are delayed by exactly `NUM_PIPELINE` cycles.
- `send` stage registers reset to 0. Payload stages (`data`, `dest`, `is_tail`) are not reset.
- Downstream logic qualifies `is_tail_out`, `data_out` and `dest_out` only with `send_out`.

**Reverse delay line**
- `credit_in` is delayed `NUM_PIPELINE` cycles to `credit_out`.
- Credit stage registers reset to 0.

**Shadow credit counter**
- Width is clog2(FLIT_BUFFER_DEPTH+1). Reset value is `FLIT_BUFFER_DEPTH`.
- It is observed at the upstream side, using `send_in` and `credit_out`.
- `send_in` alone: decrement. `credit_out` alone: increment. Both in the same cycle: hold.
- `send_in` alone while the count is 0: set `err_credit_overflow` and hold the count at 0.
- `credit_out` alone while the count is `FLIT_BUFFER_DEPTH`: set `err_credit_underflow` and hold.
- `clear_stats` does not reset the credit counter.

**Framing FSM** (states IDLE and IN_PKT; reset state IDLE)
- IDLE: `send_in` && !`is_tail_in` → capture `dest_in`, go to IN_PKT. A single-flit packet (`send_in` && `is_tail_in`) stays in IDLE.
- IN_PKT: `send_in` with `dest_in` != captured value → set `err_framing`; the state advances as normal.
- IN_PKT: `send_in` && `is_tail_in` → go to IDLE.

**Counters and flags**
- `flit_count` increments on each `send_in`.
- `packet_count` increments on each `send_in` && `is_tail_in`.
- Both counters wrap modulo 2^COUNT_WIDTH.
- `clear_stats` zeroes both counters and all three error flags. If an event occurs in the same cycle as `clear_stats`, the clear wins and that event is not counted or flagged.

**Reset values**
- `send_out`, `credit_out`, both counters and all error flags are 0.
- With `NUM_PIPELINE`=0 the outputs follow the inputs combinationally, including during reset.

**Reset mid-operation**
- Flits and credits in flight in the delay lines are discarded.
- The credit counter returns to `FLIT_BUFFER_DEPTH`; the FSM returns to IDLE.

## Timing
- Forward latency: `send_in` at cycle t appears on `send_out` at cycle t+NUM_PIPELINE.
- Credit latency: `credit_in` at cycle t appears on `credit_out` at cycle t+NUM_PIPELINE.
- The link adds no buffering and no backpressure. Throughput is one flit and one credit per cycle.
- Counters and error flags are registered. They reflect an event at cycle t starting at cycle t+1.
- Upstream sees a round-trip credit loop lengthened by 2·NUM_PIPELINE cycles. `FLIT_BUFFER_DEPTH` must cover this for full throughput; the link itself does not enforce it.

## Structure
- Package `noc_link_pkg` holds:
  - the `link_state_e` enum (IDLE, IN_PKT);
  - the error-index localparams (ERR_OVF=0, ERR_UNF=1, ERR_FRM=2);
  - a helper function for the credit counter width.
- Sub-module `noc_link_delay_line`:
  - parameterised by WIDTH and STAGES;
  - has a separate reset-valued valid bit and non-reset payload bits;
  - STAGES=0 gives plain wires.
  - It is instantiated twice: forward path with WIDTH = FLIT_WIDTH+DEST_WIDTH+1 plus the valid bit; credit path with valid bit only.
- The top level holds the credit counter, the framing FSM and the counters.

## Test plan
- **Latency:** NUM_PIPELINE=2; flit with data 0xA5, dest 4'h3 at cycle 10 → `send_out` high only at cycle 12 with the same data and dest; `credit_in` at cycle 20 → `credit_out` at cycle 22.
- **Full throughput:** 8 back-to-back flits with DEPTH=8 and no credits returned → count reaches 0 and no error. A 9th flit → `err_credit_overflow` is 1 from the next cycle and the count stays 0.
- **Underflow and simultaneity:**
  - A credit returned with the count at 8 → `err_credit_underflow` set.
  - With the count at 5, `send_in` and `credit_out` in the same cycle → count remains 5.
- **Framing:**
  - 3-flit packet with dest 2,2,2 → no error; `packet_count`=1; `flit_count`=3.
  - Packet with dest 2,1 → `err_framing` set.
  - A single-flit packet → FSM stays in IDLE.
- **Wrap and clear:**
  - COUNT_WIDTH=4 and 17 flits → `flit_count`=1.
  - `clear_stats` asserted in the same cycle as a flit → counters and flags 0 the next cycle, and that flit is not counted.
- **Reset mid-stream:** assert `rst_n`=0 while 2 flits are in flight (NUM_PIPELINE=2) → `send_out` goes to 0 immediately and stays 0 after release; the credit count reads 8.
